// File: rtl/msg_pkg.sv
// Shared types, ASCII constants and frame character lookup for the telemetry framer.
package msg_pkg;

    localparam logic [7:0] CH_A    = 8'h41;
    localparam logic [7:0] CH_B    = 8'h42;
    localparam logic [7:0] CH_C    = 8'h43;
    localparam logic [7:0] CH_D    = 8'h44;
    localparam logic [7:0] CH_E    = 8'h45;
    localparam logic [7:0] CH_F    = 8'h46;
    localparam logic [7:0] CH_I    = 8'h49;
    localparam logic [7:0] CH_M    = 8'h4D;
    localparam logic [7:0] CH_N    = 8'h4E;
    localparam logic [7:0] CH_P    = 8'h50;
    localparam logic [7:0] CH_R    = 8'h52;
    localparam logic [7:0] CH_S    = 8'h53;
    localparam logic [7:0] CH_U    = 8'h55;
    localparam logic [7:0] CH_0    = 8'h30;
    localparam logic [7:0] CH_1    = 8'h31;
    localparam logic [7:0] CH_DASH = 8'h2D;
    localparam logic [7:0] CH_HASH = 8'h23;
    localparam logic [7:0] CH_QM   = 8'h3F;

    typedef enum logic [1:0] {EVT_FAULT, EVT_PICKUP, EVT_DEPOSIT, EVT_END} evt_type_e;
    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SEND, ST_GAP} state_e;

    typedef struct packed {
        evt_type_e   kind;
        logic [1:0]  unit_code;
        logic [2:0]  sub_id;
        logic [1:0]  block;
    } evt_rec_t;

    function automatic logic [7:0] unit_char(input logic [1:0] u);
        case (u)
            2'd1:    return CH_E;
            2'd2:    return CH_C;
            2'd3:    return CH_R;
            default: return CH_QM;
        endcase
    endfunction

    function automatic logic [7:0] id_char(input logic [2:0] i);
        if (i >= 3'd1 && i <= 3'd4) return CH_0 + {5'd0, i};
        return CH_0;
    endfunction

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? CH_0 + {4'd0, n} : CH_A + {4'd0, n - 4'd10};
    endfunction

    function automatic logic [3:0] base_len(input evt_type_e t);
        case (t)
            EVT_FAULT:   return 4'd10;
            EVT_PICKUP:  return 4'd11;
            EVT_DEPOSIT: return 4'd13;
            default:     return 4'd5;
        endcase
    endfunction

    // Unchecked frame text; every position past the last listed one reads as '#'.
    function automatic logic [7:0] base_char(input evt_rec_t r, input logic [3:0] idx);
        logic [7:0] u, i, b;
        u = unit_char(r.unit_code);
        i = id_char(r.sub_id);
        b = CH_1 + {6'd0, r.block};
        case (r.kind)
            EVT_FAULT: case (idx)
                4'd0: return CH_F;    4'd1: return CH_I;    4'd2: return CH_M;
                4'd3: return CH_DASH; 4'd4: return u;       4'd5: return CH_S;
                4'd6: return CH_U;    4'd7: return i;       4'd8: return CH_DASH;
                default: return CH_HASH;
            endcase
            EVT_PICKUP: case (idx)
                4'd0: return CH_B;    4'd1: return CH_P;    4'd2: return CH_M;
                4'd3: return CH_DASH; 4'd4: return CH_S;    4'd5: return CH_U;
                4'd6: return CH_DASH; 4'd7: return CH_B;    4'd8: return b;
                4'd9: return CH_DASH;
                default: return CH_HASH;
            endcase
            EVT_DEPOSIT: case (idx)
                4'd0: return CH_B;    4'd1: return CH_D;    4'd2: return CH_M;
                4'd3: return CH_DASH; 4'd4: return u;       4'd5: return CH_S;
                4'd6: return CH_U;    4'd7: return i;       4'd8: return CH_DASH;
                4'd9: return CH_B;    4'd10: return b;      4'd11: return CH_DASH;
                default: return CH_HASH;
            endcase
            default: case (idx)
                4'd0: return CH_E;    4'd1: return CH_N;    4'd2: return CH_D;
                4'd3: return CH_DASH;
                default: return CH_HASH;
            endcase
        endcase
    endfunction

endpackage

// File: rtl/msg_evt_fifo.sv
// Event record queue: DEPTH x 9-bit synchronous FIFO with registered occupancy count.
module msg_evt_fifo import msg_pkg::*; #(
    parameter int DEPTH = 4
) (
    input  logic                      clk_50M,
    input  logic                      rst_n,
    input  logic                      push,
    input  evt_rec_t                  wr_data,
    input  logic                      pop,
    output evt_rec_t                  rd_data,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int AW = $clog2(DEPTH);

    evt_rec_t        mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk_50M) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/msg_framer.sv
// Queued status-message framer streaming ASCII frames to the UART over valid/ready.
// Define MSG_FRAMER_CHECKSUM_EN to append a two-digit hex XOR checksum before '#'.
module msg_framer import msg_pkg::*; #(
    parameter int DEPTH    = 4,
    parameter int BYTE_GAP = 4340,
    parameter int CNT_W    = 8
) (
    input  logic             clk_50M,
    input  logic             rst_n,
    input  logic             evt_valid,
    input  logic [1:0]       evt_type,
    input  logic [1:0]       evt_unit,
    input  logic [2:0]       evt_id,
    input  logic [1:0]       evt_block,
    output logic             evt_ready,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             busy,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam int GAP_W = (BYTE_GAP > 1) ? $clog2(BYTE_GAP) : 1;

    evt_rec_t                wr_rec, head, frame_q, src;
    logic                    fifo_full, fifo_empty;
    logic [$clog2(DEPTH):0]  fifo_count;
    state_e                  state_q;
    logic [3:0]              idx_q, cidx;
    logic [GAP_W-1:0]        gap_q;
    logic                    done_q;
    logic [7:0]              char_out;
`ifdef MSG_FRAMER_CHECKSUM_EN
    logic [3:0]              blen;
    logic [7:0]              csum_q, csum_nxt, ccs;
`endif

    assign wr_rec    = '{kind: evt_type_e'(evt_type), unit_code: evt_unit,
                         sub_id: evt_id, block: evt_block};
    assign evt_ready = !fifo_full;
    assign busy      = (state_q != ST_IDLE) || (fifo_count != '0);

    msg_evt_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_50M (clk_50M),
        .rst_n   (rst_n),
        .push    (evt_valid && evt_ready),
        .wr_data (wr_rec),
        .pop     (state_q == ST_LOAD),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Byte about to be registered: first byte in LOAD, next byte in SEND, current in GAP.
    always_comb begin
        src = (state_q == ST_LOAD) ? head : frame_q;
        case (state_q)
            ST_LOAD: cidx = 4'd0;
            ST_SEND: cidx = idx_q + 4'd1;
            default: cidx = idx_q;
        endcase
        char_out = base_char(src, cidx);
`ifdef MSG_FRAMER_CHECKSUM_EN
        blen     = base_len(src.kind);
        csum_nxt = (idx_q < blen - 4'd1) ? (csum_q ^ tx_data) : csum_q;
        ccs      = (state_q == ST_SEND) ? csum_nxt : csum_q;
        if (cidx == blen - 4'd1)  char_out = hex_char(ccs[7:4]);
        else if (cidx == blen)    char_out = hex_char(ccs[3:0]);
        else if (cidx > blen)     char_out = CH_HASH;
`endif
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            frame_q  <= '0;
            idx_q    <= '0;
            gap_q    <= '0;
            done_q   <= 1'b0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            drop_cnt <= '0;
`ifdef MSG_FRAMER_CHECKSUM_EN
            csum_q   <= '0;
`endif
        end else begin
            if (evt_valid && !evt_ready && drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
            case (state_q)
                ST_IDLE: if (!fifo_empty) state_q <= ST_LOAD;
                ST_LOAD: begin
                    frame_q  <= head;
                    idx_q    <= '0;
                    tx_data  <= char_out;
                    tx_valid <= 1'b1;
                    state_q  <= ST_SEND;
`ifdef MSG_FRAMER_CHECKSUM_EN
                    csum_q   <= '0;
`endif
                end
                ST_SEND: if (tx_ready) begin
`ifdef MSG_FRAMER_CHECKSUM_EN
                    csum_q <= csum_nxt;
`endif
                    idx_q  <= idx_q + 4'd1;
                    done_q <= (tx_data == CH_HASH);
                    gap_q  <= '0;
                    if (tx_data == CH_HASH) begin
                        tx_valid <= 1'b0;
                        if (BYTE_GAP == 0) state_q <= fifo_empty ? ST_IDLE : ST_LOAD;
                        else               state_q <= ST_GAP;
                    end else if (BYTE_GAP == 0) begin
                        tx_data <= char_out;
                    end else begin
                        tx_valid <= 1'b0;
                        state_q  <= ST_GAP;
                    end
                end
                default: begin
                    if (gap_q == GAP_W'(BYTE_GAP - 1)) begin
                        if (done_q) begin
                            state_q <= fifo_empty ? ST_IDLE : ST_LOAD;
                        end else begin
                            tx_valid <= 1'b1;
                            tx_data  <= char_out;
                            state_q  <= ST_SEND;
                        end
                    end else begin
                        gap_q <= gap_q + GAP_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_msg_framer.sv
// Scoreboard bench for msg_framer: expected frame bytes queued at stimulus, checked at each handshake.
module tb_msg_framer;

    localparam int GAP = 2;
`ifdef MSG_FRAMER_CHECKSUM_EN
    localparam int CS = 2;
`else
    localparam int CS = 0;
`endif

    logic       clk_50M = 1'b0;
    logic       rst_n;
    logic       evt_valid;
    logic [1:0] evt_type, evt_unit, evt_block;
    logic [2:0] evt_id;
    logic       evt_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic [7:0] drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q[$];
    int   hs_cnt = 0, frames_done = 0, frame_gap = 0, low_run = 0;
    bit   prev_stall = 0, gap_track = 0, after_hash = 0;
    logic [7:0] prev_data;

    bit [1:0] t3[7] = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd3};
    bit [1:0] u3[7] = '{2'd0, 2'd1, 2'd0, 2'd3, 2'd2, 2'd0, 2'd0};
    bit [2:0] i3[7] = '{3'd0, 3'd1, 3'd0, 3'd2, 3'd4, 3'd0, 3'd0};
    bit [1:0] b3[7] = '{2'd0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd3, 2'd0};

    msg_framer #(.DEPTH(4), .BYTE_GAP(GAP), .CNT_W(8)) dut (
        .clk_50M   (clk_50M),
        .rst_n     (rst_n),
        .evt_valid (evt_valid),
        .evt_type  (evt_type),
        .evt_unit  (evt_unit),
        .evt_id    (evt_id),
        .evt_block (evt_block),
        .evt_ready (evt_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .drop_cnt  (drop_cnt)
    );

    always #10 clk_50M = ~clk_50M;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic string frame_str(input bit [1:0] t, input bit [1:0] u,
                                        input bit [2:0] i, input bit [1:0] b);
        string s, uc, ic, bc;
        bit [7:0] x;
        uc = (u == 1) ? "E" : (u == 2) ? "C" : (u == 3) ? "R" : "?";
        ic = (i >= 1 && i <= 4) ? $sformatf("%0d", i) : "0";
        bc = $sformatf("%0d", int'(b) + 1);
        case (t)
            2'd0:    s = {"FIM-", uc, "SU", ic, "-"};
            2'd1:    s = {"BPM-SU-B", bc, "-"};
            2'd2:    s = {"BDM-", uc, "SU", ic, "-B", bc, "-"};
            default: s = "END-";
        endcase
`ifdef MSG_FRAMER_CHECKSUM_EN
        x = 8'h00;
        for (int k = 0; k < s.len(); k++) x = x ^ s[k];
        s = {s, $sformatf("%02X", x)};
`endif
        return {s, "#"};
    endfunction

    task automatic push_frame(input bit [1:0] t, input bit [1:0] u, input bit [2:0] i, input bit [1:0] b);
        string s;
        s = frame_str(t, u, i, b);
        for (int k = 0; k < s.len(); k++) exp_q.push_back(s[k]);
    endtask

    task automatic drive_evt(input bit [1:0] t, input bit [1:0] u, input bit [2:0] i, input bit [1:0] b);
        evt_valid = 1'b1;
        evt_type  = t;
        evt_unit  = u;
        evt_id    = i;
        evt_block = b;
    endtask

    // Offer one event into a non-full queue for a single cycle.
    task automatic send_evt(input bit [1:0] t, input bit [1:0] u, input bit [2:0] i, input bit [1:0] b);
        drive_evt(t, u, i, b);
        check("evt_ready_accept", evt_ready, 1);
        push_frame(t, u, i, b);
        @(posedge clk_50M); #1;
        evt_valid = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        for (int k = 0; k < bound; k++) begin
            if (!busy && exp_q.size() == 0 && !tx_valid) break;
            @(posedge clk_50M); #1;
        end
        check("idle_busy", busy, 0);
        check("exp_drained", exp_q.size(), 0);
    endtask

    // Monitor: samples on the falling edge, a handshake completes on the next rising edge.
    always @(negedge clk_50M) begin
        if (!rst_n) begin
            prev_stall = 0;
            gap_track  = 0;
            after_hash = 0;
            low_run    = 0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", tx_valid, 1);
                check("stall_data", tx_data, prev_data);
            end
            if (tx_valid) begin
                if (gap_track) begin
                    if (after_hash) frame_gap = low_run;
                    else            check("byte_gap", low_run, GAP);
                    gap_track = 0;
                end
                if (tx_ready) begin
                    if (exp_q.size() == 0) check("extra_byte", tx_data, 0);
                    else                   check("tx_byte", tx_data, exp_q.pop_front());
                    hs_cnt++;
                    after_hash = (tx_data == "#");
                    if (after_hash) frames_done++;
                    gap_track = 1;
                    low_run   = 0;
                end
            end else begin
                low_run++;
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end
    end

    initial begin
        int hs0, f0, hs_r;
        rst_n     = 1'b0;
        evt_valid = 1'b0;
        evt_type  = '0;
        evt_unit  = '0;
        evt_id    = '0;
        evt_block = '0;
        tx_ready  = 1'b1;
        repeat (3) @(posedge clk_50M);
        #1;
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_evt_ready", evt_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        rst_n = 1'b1;
        @(posedge clk_50M); #1;

        // FAULT C3: latency and intra-frame gaps
        hs0 = hs_cnt;
        send_evt(2'd0, 2'd2, 3'd3, 2'd0);
        @(posedge clk_50M); #1;
        check("lat_load_valid", tx_valid, 0);
        @(posedge clk_50M); #1;
        check("lat_first_valid", tx_valid, 1);
        check("lat_first_byte", tx_data, "F");
        wait_idle(500);
        check("fault_byte_count", hs_cnt - hs0, 10 + CS);

        // PICKUP then DEPOSIT back-to-back
        hs0 = hs_cnt;
        send_evt(2'd1, 2'd0, 3'd0, 2'd1);
        send_evt(2'd2, 2'd1, 3'd4, 2'd3);
        wait_idle(1000);
        check("pair_byte_count", hs_cnt - hs0, 24 + 2 * CS);
        check("frame_gap", frame_gap, GAP + 1);

        // Fill with UART stalled: five accepted, two dropped
        tx_ready = 1'b0;
        f0 = frames_done;
        for (int k = 0; k < 7; k++) begin
            drive_evt(t3[k], u3[k], i3[k], b3[k]);
            check("fill_evt_ready", evt_ready, (k < 5) ? 1 : 0);
            if (k < 5) push_frame(t3[k], u3[k], i3[k], b3[k]);
            @(posedge clk_50M); #1;
        end
        evt_valid = 1'b0;
        check("fill_drop_cnt", drop_cnt, 2);
        check("fill_still_full", evt_ready, 0);
        check("fill_busy", busy, 1);
        tx_ready = 1'b1;
        wait_idle(2000);
        check("fill_frames", frames_done - f0, 5);
        check("fill_ready_again", evt_ready, 1);
        check("fill_drop_hold", drop_cnt, 2);

        // END with random back-pressure
        tx_ready = 1'b0;
        hs0 = hs_cnt;
        send_evt(2'd3, 2'd0, 3'd0, 2'd0);
        for (int k = 0; k < 400 && (busy || exp_q.size() != 0); k++) begin
            tx_ready = 1'($urandom_range(0, 1));
            @(posedge clk_50M); #1;
        end
        tx_ready = 1'b1;
        check("end_handshakes", hs_cnt - hs0, 5 + CS);
        check("end_busy_low", busy, 0);

        // Reset during the fourth byte of a FAULT frame with two events queued
        hs0 = hs_cnt;
        send_evt(2'd0, 2'd3, 3'd1, 2'd2);
        send_evt(2'd3, 2'd0, 3'd0, 2'd0);
        send_evt(2'd1, 2'd0, 3'd0, 2'd2);
        for (int k = 0; k < 200 && !((hs_cnt - hs0) >= 3 && tx_valid); k++) begin
            @(posedge clk_50M); #1;
        end
        check("rst_at_byte4", hs_cnt - hs0, 3);
        check("rst_pre_valid", tx_valid, 1);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("rst_mid_valid", tx_valid, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_ready", evt_ready, 1);
        hs_r = hs_cnt;
        repeat (2) @(posedge clk_50M);
        #1;
        rst_n = 1'b1;
        repeat (60) @(posedge clk_50M);
        #1;
        check("post_rst_no_bytes", hs_cnt - hs_r, 0);
        check("post_rst_busy", busy, 0);
        check("post_rst_valid", tx_valid, 0);
        check("post_rst_drop", drop_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
